// File: rtl/conv_seq_pkg.sv
// Shared definitions for the convolution stream sequencer: FSM states,
// config register map, error codes and CONTROL register bit positions.
package conv_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_KERN  = 2'd1,
    ST_FEAT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [4:0] ADDR_KW   = 5'd0;
  localparam logic [4:0] ADDR_FW   = 5'd1;
  localparam logic [4:0] ADDR_CTRL = 5'd2;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_OVERFLOW = 2'd1;
  localparam logic [1:0] ERR_CLOSED   = 2'd2;
  localparam logic [1:0] ERR_ABORT    = 2'd3;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_ABORT_BIT = 1;

endpackage

// File: rtl/conv_seq_out_reg.sv
// One-entry valid/ready output register carrying a data word plus its
// kernel/feature tag and end-of-phase marker. A flush empties it at once.
module conv_seq_out_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_kernel,
  input  logic              load_last,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              is_kernel,
  output logic              last
);

  // Load on accept, drain on ready, drop everything on flush; payload only
  // changes on a load so it stays stable while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid     <= 1'b0;
      data      <= '0;
      is_kernel <= 1'b0;
      last      <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid     <= 1'b1;
      data      <= load_data;
      is_kernel <= load_kernel;
      last      <= load_last;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/conv_stream_sequencer.sv
// Sequences a kernel phase then a feature phase from two host write streams
// into one tagged, backpressured stream, with config registers, error
// reporting and a done pulse once the pipeline has drained.
module conv_stream_sequencer
  import conv_seq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 20
) (
  input  logic              bus_clk,
  input  logic              bus_rst_n,
  input  logic              cfg_wren,
  input  logic [4:0]        cfg_addr,
  input  logic [31:0]       cfg_data,
  input  logic              kern_open,
  input  logic              kern_wren,
  input  logic [DATA_W-1:0] kern_data,
  output logic              kern_full,
  input  logic              feat_open,
  input  logic              feat_wren,
  input  logic [DATA_W-1:0] feat_data,
  output logic              feat_full,
  output logic              pipe_valid,
  output logic [DATA_W-1:0] pipe_data,
  output logic              pipe_is_kernel,
  output logic              pipe_last,
  input  logic              pipe_ready,
  input  logic              pipe_busy,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  state_t           state_reg;
  logic [CNT_W-1:0] kw_reg;
  logic [CNT_W-1:0] fw_reg;
  logic [CNT_W-1:0] rem_reg;
  logic             done_reg;
  logic             err_reg;
  logic [1:0]       err_code_reg;

  logic cfg_start, cfg_abort, rem_nz, rem_one, out_free;
  logic kern_acc, feat_acc, acc;
  logic kern_ovf, feat_ovf, closed_err, abort_err, flush;
  logic cfg_unused;

  assign cfg_start = cfg_wren && (cfg_addr == ADDR_CTRL) && cfg_data[CTRL_START_BIT];
  assign cfg_abort = cfg_wren && (cfg_addr == ADDR_CTRL) && cfg_data[CTRL_ABORT_BIT];
  assign cfg_unused = ^cfg_data[31:CNT_W];

  assign rem_nz   = (rem_reg != '0);
  assign rem_one  = (rem_reg == CNT_W'(1));
  assign out_free = ~pipe_valid | pipe_ready;

  // Backpressure depends only on registered state and pipe_ready.
  assign kern_full = ~((state_reg == ST_KERN) && rem_nz && out_free);
  assign feat_full = ~((state_reg == ST_FEAT) && rem_nz && out_free);

  assign kern_acc = kern_wren & ~kern_full;
  assign feat_acc = feat_wren & ~feat_full;
  assign acc      = kern_acc | feat_acc;

  assign kern_ovf   = kern_wren & kern_full;
  assign feat_ovf   = feat_wren & feat_full;
  assign closed_err = ((state_reg == ST_KERN) && !kern_open && rem_nz) ||
                      ((state_reg == ST_FEAT) && !feat_open && rem_nz);
  assign abort_err  = cfg_abort && (state_reg != ST_IDLE);
  // Terminating errors discard the output entry even if a word was accepted.
  assign flush      = closed_err | abort_err;

  assign busy     = (state_reg != ST_IDLE);
  assign done     = done_reg;
  assign err      = err_reg;
  assign err_code = err_code_reg;

  conv_seq_out_reg #(.DATA_W(DATA_W)) u_out_reg (
    .clk         (bus_clk),
    .rst_n       (bus_rst_n),
    .flush       (flush),
    .load        (acc),
    .load_data   (kern_acc ? kern_data : feat_data),
    .load_kernel (kern_acc),
    .load_last   (acc && rem_one),
    .ready       (pipe_ready),
    .valid       (pipe_valid),
    .data        (pipe_data),
    .is_kernel   (pipe_is_kernel),
    .last        (pipe_last)
  );

  // Word-count registers are writable only while idle.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      kw_reg <= '0;
      fw_reg <= '0;
    end else if (cfg_wren && state_reg == ST_IDLE) begin
      if (cfg_addr == ADDR_KW) kw_reg <= cfg_data[CNT_W-1:0];
      if (cfg_addr == ADDR_FW) fw_reg <= cfg_data[CNT_W-1:0];
    end
  end

  // Phase FSM; error updates come last so they override normal progress.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      state_reg    <= ST_IDLE;
      rem_reg      <= '0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      err_code_reg <= ERR_NONE;
    end else begin
      done_reg <= 1'b0;
      unique case (state_reg)
        ST_IDLE: begin
          if (cfg_start && !cfg_abort) begin
            err_reg      <= 1'b0;
            err_code_reg <= ERR_NONE;
            rem_reg      <= kw_reg;
            if (kw_reg != '0) begin
              state_reg <= ST_KERN;
            end else if (fw_reg != '0) begin
              state_reg <= ST_FEAT;
              rem_reg   <= fw_reg;
            end else begin
              done_reg <= 1'b1;
            end
          end
        end
        ST_KERN: begin
          if (kern_acc) begin
            rem_reg <= rem_reg - 1'b1;
            if (rem_one) begin
              rem_reg   <= fw_reg;
              state_reg <= (fw_reg != '0) ? ST_FEAT : ST_DRAIN;
            end
          end
        end
        ST_FEAT: begin
          if (feat_acc) begin
            rem_reg <= rem_reg - 1'b1;
            if (rem_one) state_reg <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!pipe_valid && !pipe_busy) begin
            done_reg  <= 1'b1;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase

      if (kern_ovf || feat_ovf) begin
        err_reg      <= 1'b1;
        err_code_reg <= ERR_OVERFLOW;
      end
      if (closed_err) begin
        err_reg      <= 1'b1;
        err_code_reg <= ERR_CLOSED;
        state_reg    <= ST_IDLE;
        rem_reg      <= '0;
        done_reg     <= 1'b0;
      end
      if (abort_err) begin
        err_reg      <= 1'b1;
        err_code_reg <= ERR_ABORT;
        state_reg    <= ST_IDLE;
        rem_reg      <= '0;
        done_reg     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_stream_sequencer.sv
// Directed self-checking bench for conv_stream_sequencer. Inputs change on the
// falling clock edge; outputs are sampled 1 ns later.
module tb_conv_stream_sequencer;

  logic        bus_clk = 1'b0;
  logic        bus_rst_n = 1'b0;
  logic        cfg_wren = 1'b0;
  logic [4:0]  cfg_addr = '0;
  logic [31:0] cfg_data = '0;
  logic        kern_open = 1'b1;
  logic        kern_wren = 1'b0;
  logic [31:0] kern_data = '0;
  logic        kern_full;
  logic        feat_open = 1'b1;
  logic        feat_wren = 1'b0;
  logic [31:0] feat_data = '0;
  logic        feat_full;
  logic        pipe_valid;
  logic [31:0] pipe_data;
  logic        pipe_is_kernel;
  logic        pipe_last;
  logic        pipe_ready = 1'b1;
  logic        pipe_busy = 1'b0;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  int errors = 0;
  int checks = 0;

  always #5 bus_clk = ~bus_clk;

  conv_stream_sequencer dut (
    .bus_clk        (bus_clk),
    .bus_rst_n      (bus_rst_n),
    .cfg_wren       (cfg_wren),
    .cfg_addr       (cfg_addr),
    .cfg_data       (cfg_data),
    .kern_open      (kern_open),
    .kern_wren      (kern_wren),
    .kern_data      (kern_data),
    .kern_full      (kern_full),
    .feat_open      (feat_open),
    .feat_wren      (feat_wren),
    .feat_data      (feat_data),
    .feat_full      (feat_full),
    .pipe_valid     (pipe_valid),
    .pipe_data      (pipe_data),
    .pipe_is_kernel (pipe_is_kernel),
    .pipe_last      (pipe_last),
    .pipe_ready     (pipe_ready),
    .pipe_busy      (pipe_busy),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .err_code       (err_code)
  );

  // Called at a falling edge; returns at the falling edge after the write edge.
  task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
    cfg_wren = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    @(negedge bus_clk);
    cfg_wren = 1'b0;
    cfg_data = '0;
    $display("cfg write addr=%0d data=0x%08h", a, d);
  endtask

  // Reset values of every output, sampled now.
  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({kern_full, feat_full} !== 2'b11) begin
      errors++;
      $display("FAIL %s full: got kern=%b feat=%b expected 1/1", tag, kern_full, feat_full);
    end
    checks++;
    if ({pipe_valid, pipe_is_kernel, pipe_last, busy, done, err} !== 6'b0) begin
      errors++;
      $display("FAIL %s flags: got valid=%b kern=%b last=%b busy=%b done=%b err=%b expected all 0",
               tag, pipe_valid, pipe_is_kernel, pipe_last, busy, done, err);
    end
    checks++;
    if (pipe_data !== 32'h0 || err_code !== 2'd0) begin
      errors++;
      $display("FAIL %s data/code: got data=0x%08h code=%0d expected 0/0", tag, pipe_data, err_code);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge bus_clk);
    #1 check_reset_outputs("reset_hold");
    @(negedge bus_clk);
    bus_rst_n = 1'b1;
    @(negedge bus_clk);
    #1 check_reset_outputs("reset_release");
    @(negedge bus_clk);
  endtask

  // Full job: host writers push whenever not full, consumer checks every word
  // against the expected order, pipe_busy drops a few cycles after the last word.
  task automatic run_job(input int kw, input int fw, input bit rnd, input string name);
    int kacc = 0;
    int facc = 0;
    int got = 0;
    int dones = 0;
    int tail = 0;
    int post = 0;
    int total = kw + fw;
    bit prev_stall = 0;
    logic [31:0] prev_data = '0;
    logic [1:0] prev_tags = '0;
    logic [31:0] exp_data;
    logic exp_kern, exp_last;
    pipe_busy = 1'b1;
    cfg_write(5'd0, kw);
    cfg_write(5'd1, fw);
    cfg_write(5'd2, 32'h1);
    #1;
    checks++;
    if (busy !== (total != 0)) begin
      errors++;
      $display("FAIL %s busy_after_start: got %b expected %b", name, busy, total != 0);
    end
    @(negedge bus_clk);
    for (int cyc = 0; cyc < 5000; cyc++) begin
      pipe_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      kern_wren = 1'b0;
      feat_wren = 1'b0;
      #1;
      if (kw == 0) begin
        checks++;
        if (kern_full !== 1'b1) begin
          errors++;
          $display("FAIL %s kern_full_skip: got %b expected 1", name, kern_full);
        end
      end
      if (kacc < kw && !kern_full) begin
        kern_wren = 1'b1;
        kern_data = 32'hA000_0000 + 32'(kacc);
        kacc++;
      end
      if (facc < fw && !feat_full) begin
        feat_wren = 1'b1;
        feat_data = 32'hB000_0000 + 32'(facc);
        facc++;
      end
      if (prev_stall) begin
        checks++;
        if (!pipe_valid || pipe_data !== prev_data || {pipe_is_kernel, pipe_last} !== prev_tags) begin
          errors++;
          $display("FAIL %s stall_hold: got valid=%b data=0x%08h tags=%b expected 1 0x%08h %b",
                   name, pipe_valid, pipe_data, {pipe_is_kernel, pipe_last}, prev_data, prev_tags);
        end
      end
      if (pipe_valid && pipe_ready) begin
        if (got < kw) begin
          exp_data = 32'hA000_0000 + 32'(got);
          exp_kern = 1'b1;
          exp_last = (got == kw - 1);
        end else begin
          exp_data = 32'hB000_0000 + 32'(got - kw);
          exp_kern = 1'b0;
          exp_last = (got - kw == fw - 1);
        end
        checks++;
        if (got >= total || pipe_data !== exp_data || pipe_is_kernel !== exp_kern || pipe_last !== exp_last) begin
          errors++;
          $display("FAIL %s word%0d: got 0x%08h kern=%b last=%b expected 0x%08h kern=%b last=%b",
                   name, got, pipe_data, pipe_is_kernel, pipe_last, exp_data, exp_kern, exp_last);
        end else begin
          $display("%s word %0d data=0x%08h kern=%b last=%b", name, got, pipe_data, pipe_is_kernel, pipe_last);
        end
        got++;
      end
      prev_stall = pipe_valid && !pipe_ready;
      prev_data = pipe_data;
      prev_tags = {pipe_is_kernel, pipe_last};
      if (done) begin
        dones++;
        checks++;
        if (pipe_busy || got != total) begin
          errors++;
          $display("FAIL %s done_early: got done with pipe_busy=%b words=%0d expected pipe_busy=0 words=%0d",
                   name, pipe_busy, got, total);
        end
      end
      if (got == total && pipe_busy) begin
        tail++;
        if (tail == 4) pipe_busy = 1'b0;
      end else if (!pipe_busy) begin
        post++;
      end
      @(negedge bus_clk);
      if (post == 6) break;
    end
    kern_wren = 1'b0;
    feat_wren = 1'b0;
    pipe_ready = 1'b1;
    #1;
    checks++;
    if (got != total || kacc != kw || facc != fw) begin
      errors++;
      $display("FAIL %s word_count: got out=%0d kin=%0d fin=%0d expected %0d/%0d/%0d",
               name, got, kacc, facc, total, kw, fw);
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL %s done_count: got %0d expected 1", name, dones);
    end
    checks++;
    if (busy !== 1'b0 || err !== 1'b0 || pipe_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s end_state: got busy=%b err=%b valid=%b expected 0/0/0", name, busy, err, pipe_valid);
    end
    @(negedge bus_clk);
  endtask

  task automatic test_zero_counts();
    cfg_write(5'd0, 32'd0);
    cfg_write(5'd1, 32'd0);
    cfg_write(5'd2, 32'h1);
    #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || pipe_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_counts_done: got done=%b busy=%b valid=%b expected 1/0/0", done, busy, pipe_valid);
    end
    @(negedge bus_clk);
    #1;
    checks++;
    if (done !== 1'b0 || pipe_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_counts_pulse: got done=%b valid=%b expected 0/0", done, pipe_valid);
    end
    @(negedge bus_clk);
  endtask

  task automatic test_overflow_idle();
    kern_wren = 1'b1;
    kern_data = 32'hDEAD_BEEF;
    @(negedge bus_clk);
    kern_wren = 1'b0;
    #1;
    checks++;
    if (err !== 1'b1 || err_code !== 2'd1) begin
      errors++;
      $display("FAIL overflow_err: got err=%b code=%0d expected 1/1", err, err_code);
    end
    checks++;
    if (busy !== 1'b0 || pipe_valid !== 1'b0) begin
      errors++;
      $display("FAIL overflow_idle: got busy=%b valid=%b expected 0/0", busy, pipe_valid);
    end
    @(negedge bus_clk);
    cfg_write(5'd0, 32'd0);
    cfg_write(5'd1, 32'd0);
    cfg_write(5'd2, 32'h1);
    #1;
    checks++;
    if (err !== 1'b0 || err_code !== 2'd0) begin
      errors++;
      $display("FAIL overflow_clear: got err=%b code=%0d expected 0/0", err, err_code);
    end
    @(negedge bus_clk);
  endtask

  task automatic test_stream_closed();
    int dones = 0;
    pipe_ready = 1'b1;
    pipe_busy = 1'b1;
    cfg_write(5'd0, 32'd0);
    cfg_write(5'd1, 32'd10);
    cfg_write(5'd2, 32'h1);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (feat_full !== 1'b0) begin
        errors++;
        $display("FAIL closed_accept%0d: got feat_full=%b expected 0", i, feat_full);
      end
      feat_wren = 1'b1;
      feat_data = 32'hC000_0000 + 32'(i);
      @(negedge bus_clk);
      feat_wren = 1'b0;
    end
    feat_open = 1'b0;
    @(negedge bus_clk);
    #1;
    checks++;
    if (err !== 1'b1 || err_code !== 2'd2 || busy !== 1'b0 || pipe_valid !== 1'b0) begin
      errors++;
      $display("FAIL closed_err: got err=%b code=%0d busy=%b valid=%b expected 1/2/0/0",
               err, err_code, busy, pipe_valid);
    end
    feat_open = 1'b1;
    pipe_busy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge bus_clk);
      #1;
      if (done) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL closed_no_done: got %0d done pulses expected 0", dones);
    end
    @(negedge bus_clk);
  endtask

  task automatic test_abort_and_reset();
    pipe_ready = 1'b1;
    pipe_busy = 1'b1;
    cfg_write(5'd0, 32'd5);
    cfg_write(5'd1, 32'd5);
    cfg_write(5'd2, 32'h1);
    for (int i = 0; i < 2; i++) begin
      kern_wren = 1'b1;
      kern_data = 32'hD000_0000 + 32'(i);
      @(negedge bus_clk);
    end
    kern_wren = 1'b0;
    cfg_write(5'd2, 32'h3);  // start and abort together: abort must win
    #1;
    checks++;
    if (err !== 1'b1 || err_code !== 2'd3 || busy !== 1'b0 || pipe_valid !== 1'b0 || kern_full !== 1'b1) begin
      errors++;
      $display("FAIL abort: got err=%b code=%0d busy=%b valid=%b kfull=%b expected 1/3/0/0/1",
               err, err_code, busy, pipe_valid, kern_full);
    end
    @(negedge bus_clk);
    cfg_write(5'd2, 32'h1);
    pipe_ready = 1'b0;
    #1;
    checks++;
    if (kern_full !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL restart_kern: got kfull=%b err=%b expected 0/0", kern_full, err);
    end
    kern_wren = 1'b1;
    kern_data = 32'hE000_0000;
    @(negedge bus_clk);
    kern_wren = 1'b0;
    #1;
    checks++;
    if (pipe_valid !== 1'b1 || pipe_data !== 32'hE000_0000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_kern: got valid=%b data=0x%08h busy=%b expected 1 0xe0000000 1",
               pipe_valid, pipe_data, busy);
    end
    bus_rst_n = 1'b0;
    #1 check_reset_outputs("reset_mid_kern");
    @(negedge bus_clk);
    bus_rst_n = 1'b1;
    pipe_ready = 1'b1;
    pipe_busy = 1'b0;
    @(negedge bus_clk);
    cfg_write(5'd2, 32'h1);  // counts were reset to 0
    #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_counts: got done=%b busy=%b expected 1/0", done, busy);
    end
    @(negedge bus_clk);
    run_job(3, 2, 1'b0, "post_reset");
  endtask

  initial begin
    test_reset();
    run_job(9, 100, 1'b0, "full_rate");
    run_job(9, 100, 1'b1, "random_ready");
    run_job(0, 4, 1'b0, "skip_kernel");
    test_zero_counts();
    test_overflow_idle();
    test_stream_closed();
    test_abort_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
